// File: rtl/axi_adapter_pkg.sv
// axi_adapter_pkg: shared AXI encodings, FSM state types and response merging
package axi_adapter_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_RESP, W_B} wr_state_e;
  // EXOKAY ranks as OKAY so the remaining codes order naturally by value
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    logic [1:0] y;
    x = (a == EXOKAY) ? OKAY : a;
    y = (b == EXOKAY) ? OKAY : b;
    return (x > y) ? x : y;
  endfunction
endpackage

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat address for an AXI burst, flagging WRAP lengths that are not 2/4/8/16
module axi_addr_gen
  import axi_adapter_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_o,
  output logic        illegal_o
);
  logic [31:0] step;
  logic [31:0] inc;
  logic [31:0] mask;
  always_comb begin
    step = 32'd1 << size_i;
    inc = addr_i + step;
    mask = (({24'd0, len_i} + 32'd1) << size_i) - 32'd1;
    illegal_o = burst_i == WRAP && !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15});
    next_o = (burst_i == INCR || (burst_i == WRAP && illegal_o)) ? inc :
             (burst_i == WRAP) ? ((addr_i & ~mask) | (inc & mask)) : addr_i;
  end
endmodule

// File: rtl/axi_burst_adapter.sv
// axi_burst_adapter: splits AXI4 bursts into single-beat downstream accesses,
// rebuilding rlast on reads and folding per-beat write responses into one B.
module axi_burst_adapter
  import axi_adapter_pkg::*;
#(
  parameter int TAGW   = 4,
  parameter int DATA_W = 64
) (
  input  logic                aclk,
  input  logic                rst_l,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [31:0]         s_araddr,
  input  logic [TAGW-1:0]     s_arid,
  input  logic [7:0]          s_arlen,
  input  logic [1:0]          s_arburst,
  input  logic [2:0]          s_arsize,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic [TAGW-1:0]     s_rid,
  output logic                s_rlast,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_awaddr,
  input  logic [TAGW-1:0]     s_awid,
  input  logic [7:0]          s_awlen,
  input  logic [1:0]          s_awburst,
  input  logic [2:0]          s_awsize,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  output logic [TAGW-1:0]     s_bid,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [31:0]         m_araddr,
  output logic [TAGW-1:0]     m_arid,
  output logic [7:0]          m_arlen,
  output logic [1:0]          m_arburst,
  output logic [2:0]          m_arsize,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic [TAGW-1:0]     m_rid,
  input  logic                m_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [31:0]         m_awaddr,
  output logic [TAGW-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [1:0]          m_awburst,
  output logic [2:0]          m_awsize,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [TAGW-1:0]     m_bid
);
  rd_state_e rs_q, rs_d;
  wr_state_e ws_q, ws_d;
  logic [31:0] ra_q, ra_d, wa_q, wa_d, r_next, w_next;
  logic [TAGW-1:0] rid_q, rid_d, wid_q, wid_d;
  logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d, wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0] rsize_q, rsize_d, wsize_q, wsize_d;
  logic [1:0] rburst_q, rburst_d, wburst_q, wburst_d, rresp_q, rresp_d, wmrg_q, wmrg_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic r_ill, w_ill, r_last, w_last, w_err;
  logic unused_inputs;
  assign unused_inputs = ^{m_rid, m_rlast, m_bid};
  axi_addr_gen u_rd_gen (.addr_i(ra_q), .size_i(rsize_q), .len_i(rlen_q), .burst_i(rburst_q),
                         .next_o(r_next), .illegal_o(r_ill));
  axi_addr_gen u_wr_gen (.addr_i(wa_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
                         .next_o(w_next), .illegal_o(w_ill));
  assign r_last = rbeat_q == rlen_q;
  assign w_last = wbeat_q == wlen_q;
  assign w_err = wburst_q == RSVD || w_ill || (s_wlast != w_last);
  always_ff @(posedge aclk or negedge rst_l)
    if (!rst_l) begin
      rs_q <= R_IDLE;
      ra_q <= '0;
      rid_q <= '0;
      rlen_q <= '0;
      rbeat_q <= '0;
      rsize_q <= '0;
      rburst_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      ws_q <= W_IDLE;
      wa_q <= '0;
      wid_q <= '0;
      wlen_q <= '0;
      wbeat_q <= '0;
      wsize_q <= '0;
      wburst_q <= '0;
      wmrg_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      rs_q <= rs_d;
      ra_q <= ra_d;
      rid_q <= rid_d;
      rlen_q <= rlen_d;
      rbeat_q <= rbeat_d;
      rsize_q <= rsize_d;
      rburst_q <= rburst_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      ws_q <= ws_d;
      wa_q <= wa_d;
      wid_q <= wid_d;
      wlen_q <= wlen_d;
      wbeat_q <= wbeat_d;
      wsize_q <= wsize_d;
      wburst_q <= wburst_d;
      wmrg_q <= wmrg_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  // Reserved reads skip the downstream access and answer SLVERR with zero data
  always_comb begin
    rs_d = rs_q;
    ra_d = ra_q;
    rid_d = rid_q;
    rlen_d = rlen_q;
    rbeat_d = rbeat_q;
    rsize_d = rsize_q;
    rburst_d = rburst_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    unique case (rs_q)
      R_IDLE: if (s_arvalid) begin
        rs_d = R_ADDR;
        ra_d = s_araddr;
        rid_d = s_arid;
        rlen_d = s_arlen;
        rsize_d = s_arsize;
        rburst_d = s_arburst;
        rbeat_d = '0;
      end
      R_ADDR: if (rburst_q == RSVD) begin
        rs_d = R_DATA;
        rdata_d = '0;
        rresp_d = SLVERR;
      end else if (m_arready) rs_d = R_WAIT;
      R_WAIT: if (m_rvalid) begin
        rs_d = R_DATA;
        rdata_d = m_rdata;
        rresp_d = resp_merge(m_rresp, r_ill ? SLVERR : OKAY);
      end
      R_DATA: if (s_rready) begin
        rs_d = r_last ? R_IDLE : R_ADDR;
        rbeat_d = r_last ? rbeat_q : rbeat_q + 8'd1;
        ra_d = r_last ? ra_q : r_next;
      end
    endcase
  end
  always_comb begin
    s_arready = rst_l && rs_q == R_IDLE;
    m_arvalid = rs_q == R_ADDR && rburst_q != RSVD;
    s_rvalid = rs_q == R_DATA;
    s_rlast = rs_q == R_DATA && r_last;
  end
  // Reserved writes consume W beats locally; every error source folds into the merged response
  always_comb begin
    ws_d = ws_q;
    wa_d = wa_q;
    wid_d = wid_q;
    wlen_d = wlen_q;
    wbeat_d = wbeat_q;
    wsize_d = wsize_q;
    wburst_d = wburst_q;
    wmrg_d = wmrg_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (ws_q)
      W_IDLE: if (s_awvalid) begin
        ws_d = W_DATA;
        wa_d = s_awaddr;
        wid_d = s_awid;
        wlen_d = s_awlen;
        wsize_d = s_awsize;
        wburst_d = s_awburst;
        wbeat_d = '0;
        wmrg_d = OKAY;
      end
      W_DATA: if (s_wvalid) begin
        wdata_d = s_wdata;
        wstrb_d = s_wstrb;
        wmrg_d = resp_merge(wmrg_q, w_err ? SLVERR : OKAY);
        ws_d = wburst_q != RSVD ? W_ISSUE : w_last ? W_B : W_DATA;
        wbeat_d = (wburst_q == RSVD && !w_last) ? wbeat_q + 8'd1 : wbeat_q;
      end
      W_ISSUE: if (m_awready && m_wready) ws_d = W_RESP;
      W_RESP: if (m_bvalid) begin
        wmrg_d = resp_merge(wmrg_q, m_bresp);
        ws_d = w_last ? W_B : W_DATA;
        wbeat_d = w_last ? wbeat_q : wbeat_q + 8'd1;
        wa_d = w_last ? wa_q : w_next;
      end
      W_B: if (s_bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end
  always_comb begin
    s_awready = rst_l && ws_q == W_IDLE;
    s_wready = ws_q == W_DATA;
    m_awvalid = ws_q == W_ISSUE;
    m_wvalid = ws_q == W_ISSUE;
    s_bvalid = ws_q == W_B;
  end
  assign s_rdata = rdata_q;
  assign s_rresp = rresp_q;
  assign s_rid = rid_q;
  assign m_araddr = ra_q;
  assign m_arid = rid_q;
  assign m_arlen = 8'd0;
  assign m_arburst = INCR;
  assign m_arsize = rsize_q;
  assign m_rready = 1'b1;
  assign s_bresp = wmrg_q;
  assign s_bid = wid_q;
  assign m_awaddr = wa_q;
  assign m_awid = wid_q;
  assign m_awlen = 8'd0;
  assign m_awburst = INCR;
  assign m_awsize = wsize_q;
  assign m_wdata = wdata_q;
  assign m_wstrb = wstrb_q;
  assign m_wlast = 1'b1;
  assign m_bready = 1'b1;
endmodule
